// File: rtl/sd_pkg.sv
// Shared definitions for the SD CMD-line controller: response-type codes, FSM states,
// CRC7 polynomial and bit positions of fields inside the receiver shift register.
package sd_pkg;

    typedef enum logic [1:0] {
        RESP_NONE  = 2'b00,
        RESP_SHORT = 2'b01,
        RESP_R2    = 2'b10,
        RESP_R3    = 2'b11
    } resp_type_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT_START,
        ST_RECV,
        ST_CHECK,
        ST_GAP
    } state_e;

    localparam logic [6:0] CRC7_POLY = 7'h09;

    // short (48-bit) response layout
    localparam int unsigned IDX_HI = 132;
    localparam int unsigned IDX_LO = 127;
    localparam int unsigned PAY_HI = 126;
    localparam int unsigned PAY_LO = 95;
    localparam int unsigned CRC_HI = 94;
    localparam int unsigned CRC_LO = 88;

    // R2 (136-bit) response layout
    localparam int unsigned R2_HI          = 126;
    localparam int unsigned R2_CRC_DATA_LO = 8;
    localparam int unsigned R2_CRC_HI      = 7;
    localparam int unsigned R2_CRC_LO      = 1;
    localparam logic [5:0]  R2_CHECK_IDX   = 6'h3F;

    localparam int unsigned SHORT_CRC_W = 40;
    localparam int unsigned R2_CRC_W    = 119;

endpackage

// File: rtl/sd_crc7_calc.sv
// Combinational CRC7 (x^7+x^3+1, zero seed) over a WIDTH-bit vector, MSB first.
module sd_crc7_calc
    import sd_pkg::*;
#(
    parameter int unsigned WIDTH = 40
) (
    input  logic [WIDTH-1:0] data,
    output logic [6:0]       crc
);

    logic [6:0] acc;
    logic       fb;

    always_comb begin
        acc = '0;
        fb  = 1'b0;
        for (int unsigned i = WIDTH; i > 0; i--) begin
            fb  = data[i-1] ^ acc[6];
            acc = {acc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
        end
    end

    assign crc = acc;

endmodule

// File: rtl/sd_cmd_ctrl.sv
// SD CMD-line transaction sequencer: send, await response, timeouts, validate, Ncc gap.
// Optional CRC7 response checking is built when SD_CMD_CRC_CHECK_EN is defined.
module sd_cmd_ctrl
    import sd_pkg::*;
#(
    parameter int unsigned NCR_MAX = 64,
    parameter int unsigned RX_MAX  = 160,
    parameter int unsigned NCC_MIN = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [5:0]   req_index,
    input  logic [31:0]  req_arg,
    input  logic [1:0]   req_resp_type,
    output logic         tx_start,
    output logic [5:0]   tx_index,
    output logic [31:0]  tx_arg,
    input  logic         tx_done,
    output logic         rx_en,
    output logic         rx_r2,
    input  logic         rx_started,
    input  logic         rx_finished,
    input  logic [134:0] rx_response,
    output logic         done,
    output logic [127:0] resp,
    output logic [2:0]   status,
    output logic         busy
);

    localparam int unsigned CNT_TOP = (RX_MAX > NCR_MAX) ? ((RX_MAX > NCC_MIN) ? RX_MAX : NCC_MIN)
                                                         : ((NCR_MAX > NCC_MIN) ? NCR_MAX : NCC_MIN);
    localparam int unsigned CW = $clog2(CNT_TOP) + 1;

    state_e       state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    resp_type_e   type_q, type_n;
    logic [5:0]   tx_index_n;
    logic [31:0]  tx_arg_n;
    logic         tx_start_n, rx_en_n, rx_r2_n, done_n;
    logic [127:0] resp_n;
    logic [2:0]   status_n;

    logic [5:0]   rsp_index;
    logic [31:0]  rsp_payload;
    logic         idx_err, crc_err;
    logic         unused_rx;

    assign rsp_index   = rx_response[IDX_HI:IDX_LO];
    assign rsp_payload = rx_response[PAY_HI:PAY_LO];
    assign unused_rx   = ^rx_response[134:133];

    always_comb begin
        idx_err = 1'b0;
        if (type_q == RESP_SHORT)
            idx_err = (rsp_index != tx_index);
        else if (type_q == RESP_R2)
            idx_err = (rsp_index != R2_CHECK_IDX);
    end

`ifdef SD_CMD_CRC_CHECK_EN
    logic [6:0] crc_short, crc_r2;

    sd_crc7_calc #(.WIDTH(SHORT_CRC_W)) u_crc_short (
        .data ({2'b00, rx_response[IDX_HI:PAY_LO]}),
        .crc  (crc_short)
    );

    sd_crc7_calc #(.WIDTH(R2_CRC_W)) u_crc_r2 (
        .data (rx_response[R2_HI:R2_CRC_DATA_LO]),
        .crc  (crc_r2)
    );

    always_comb begin
        crc_err = 1'b0;
        if (type_q == RESP_SHORT)
            crc_err = (crc_short != rx_response[CRC_HI:CRC_LO]);
        else if (type_q == RESP_R2)
            crc_err = (crc_r2 != rx_response[R2_CRC_HI:R2_CRC_LO]);
    end
`else
    assign crc_err = 1'b0;
`endif

    assign busy      = (state != ST_IDLE);
    assign req_ready = (state == ST_IDLE);

    // Response evaluation is registered on the rx_finished edge so done/resp/status are
    // presented during CHECK; GAP then runs so req_ready returns NCC_MIN+1 cycles after done.
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        type_n     = type_q;
        tx_index_n = tx_index;
        tx_arg_n   = tx_arg;
        tx_start_n = 1'b0;
        rx_en_n    = rx_en;
        rx_r2_n    = rx_r2;
        done_n     = 1'b0;
        resp_n     = resp;
        status_n   = status;
        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    state_n    = ST_SEND;
                    type_n     = resp_type_e'(req_resp_type);
                    tx_index_n = req_index;
                    tx_arg_n   = req_arg;
                    tx_start_n = 1'b1;
                end
            end
            ST_SEND: begin
                if (tx_done) begin
                    cnt_n = '0;
                    if (type_q == RESP_NONE) begin
                        state_n  = ST_GAP;
                        done_n   = 1'b1;
                        status_n = '0;
                    end else begin
                        state_n = ST_WAIT_START;
                        rx_en_n = 1'b1;
                        rx_r2_n = (type_q == RESP_R2);
                    end
                end
            end
            ST_WAIT_START: begin
                if (rx_started) begin
                    state_n = ST_RECV;
                    cnt_n   = '0;
                end else if (cnt == CW'(NCR_MAX - 1)) begin
                    state_n  = ST_GAP;
                    cnt_n    = '0;
                    rx_en_n  = 1'b0;
                    rx_r2_n  = 1'b0;
                    done_n   = 1'b1;
                    status_n = 3'b001;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            ST_RECV: begin
                if (rx_finished) begin
                    state_n  = ST_CHECK;
                    rx_en_n  = 1'b0;
                    rx_r2_n  = 1'b0;
                    done_n   = 1'b1;
                    status_n = {crc_err, idx_err, 1'b0};
                    resp_n   = (type_q == RESP_R2) ? {rx_response[R2_HI:0], 1'b1}
                                                   : {96'b0, rsp_payload};
                end else if (cnt == CW'(RX_MAX - 1)) begin
                    state_n  = ST_GAP;
                    cnt_n    = '0;
                    rx_en_n  = 1'b0;
                    rx_r2_n  = 1'b0;
                    done_n   = 1'b1;
                    status_n = 3'b001;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            ST_CHECK: begin
                state_n = ST_GAP;
                cnt_n   = CW'(1);
            end
            ST_GAP: begin
                if (cnt == CW'(NCC_MIN)) begin
                    state_n = ST_IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            type_q   <= RESP_NONE;
            tx_index <= '0;
            tx_arg   <= '0;
            tx_start <= 1'b0;
            rx_en    <= 1'b0;
            rx_r2    <= 1'b0;
            done     <= 1'b0;
            resp     <= '0;
            status   <= '0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            type_q   <= type_n;
            tx_index <= tx_index_n;
            tx_arg   <= tx_arg_n;
            tx_start <= tx_start_n;
            rx_en    <= rx_en_n;
            rx_r2    <= rx_r2_n;
            done     <= done_n;
            resp     <= resp_n;
            status   <= status_n;
        end
    end

endmodule

// File: tb/tb_sd_cmd_ctrl.sv
// Randomized self-checking bench for sd_cmd_ctrl against a transaction-level timing/response model.
module tb_sd_cmd_ctrl;

    localparam int NCR = 64;
    localparam int RXM = 160;
    localparam int NCC = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         req_valid, req_ready;
    logic [5:0]   req_index;
    logic [31:0]  req_arg;
    logic [1:0]   req_resp_type;
    logic         tx_start;
    logic [5:0]   tx_index;
    logic [31:0]  tx_arg;
    logic         tx_done;
    logic         rx_en, rx_r2, rx_started, rx_finished;
    logic [134:0] rx_response;
    logic         done;
    logic [127:0] resp;
    logic [2:0]   status;
    logic         busy;

    sd_cmd_ctrl #(.NCR_MAX(NCR), .RX_MAX(RXM), .NCC_MIN(NCC)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_index(req_index),
        .req_arg(req_arg), .req_resp_type(req_resp_type),
        .tx_start(tx_start), .tx_index(tx_index), .tx_arg(tx_arg), .tx_done(tx_done),
        .rx_en(rx_en), .rx_r2(rx_r2), .rx_started(rx_started), .rx_finished(rx_finished),
        .rx_response(rx_response),
        .done(done), .resp(resp), .status(status), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // CRC7 as the remainder of data(x)*x^7 divided by x^7+x^3+1
    function automatic logic [6:0] crc7_ref(input logic [159:0] bits, input int n);
        logic [166:0] d;
        d = {bits, 7'b0};
        for (int i = n + 6; i >= 7; i--)
            if (d[i]) d[i -: 8] = d[i -: 8] ^ 8'h89;
        return d[6:0];
    endfunction

    typedef struct {
        logic [1:0]  typ;
        logic [5:0]  idx;
        logic [31:0] arg;
        int          tx_lat;
        int          start_lat;
        int          fin_lat;
        logic [5:0]  resp_idx;
        logic [31:0] pay;
        logic        bad_crc;
    } plan_t;

    function automatic plan_t mk(input logic [1:0] typ, input logic [5:0] idx, input logic [31:0] arg,
                                 input int tx_lat, input int start_lat, input int fin_lat,
                                 input logic [5:0] resp_idx, input logic [31:0] pay, input logic bad_crc);
        plan_t p;
        p.typ = typ; p.idx = idx; p.arg = arg; p.tx_lat = tx_lat; p.start_lat = start_lat;
        p.fin_lat = fin_lat; p.resp_idx = resp_idx; p.pay = pay; p.bad_crc = bad_crc;
        return p;
    endfunction

    task automatic run_txn(input string name, input plan_t p);
        logic [134:0] rr;
        logic [6:0]   c, badmask;
        logic [2:0]   exp_st, got_st;
        logic [127:0] exp_resp, got_resp;
        logic         crc_e, idx_e, exp_win;
        bit           started, finished;
        int           s, w0, st, fin, exp_done, nd, done_t, n;
        int           win_err, tx_err, busy_err;

        rr      = {$urandom, $urandom, $urandom, $urandom, $urandom};
        badmask = p.bad_crc ? 7'(1 << $urandom_range(0, 6)) : 7'h00;
        rr[132:127] = p.resp_idx;
        if (p.typ == 2'b10) begin
            c = crc7_ref({41'b0, rr[126:8]}, 119);
            rr[7:1] = c ^ badmask;
            exp_resp = {rr[126:0], 1'b1};
        end else begin
            rr[126:95] = p.pay;
            c = crc7_ref({120'b0, 2'b00, p.resp_idx, p.pay}, 40);
            rr[94:88] = c ^ badmask;
            exp_resp = {96'b0, p.pay};
        end
`ifdef SD_CMD_CRC_CHECK_EN
        crc_e = (p.typ == 2'b01 || p.typ == 2'b10) && p.bad_crc;
`else
        crc_e = 1'b0;
`endif
        idx_e = (p.typ == 2'b01 && p.resp_idx != p.idx) || (p.typ == 2'b10 && p.resp_idx != 6'h3F);

        started  = (p.typ != 2'b00) && (p.start_lat < NCR);
        finished = started && (p.fin_lat < RXM);
        s   = 1 + p.tx_lat;
        w0  = s + 1;
        st  = w0 + p.start_lat;
        fin = st + 1 + p.fin_lat;
        if (p.typ == 2'b00)  begin exp_done = s + 1;         exp_st = 3'b000; end
        else if (!started)   begin exp_done = w0 + NCR;      exp_st = 3'b001; end
        else if (!finished)  begin exp_done = st + 1 + RXM;  exp_st = 3'b001; end
        else                 begin exp_done = fin + 1;       exp_st = {crc_e, idx_e, 1'b0}; end

        rx_response = rr;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 100) begin @(negedge clk); n++; end
        check({name, ".ready"}, req_ready, 1'b1);
        req_valid = 1'b1; req_index = p.idx; req_arg = p.arg; req_resp_type = p.typ;

        nd = 0; done_t = -1; got_st = 3'bx; got_resp = 'x;
        win_err = 0; tx_err = 0; busy_err = 0;
        for (int t = 1; t <= exp_done + NCC + 1; t++) begin
            @(negedge clk);
            if (t == 1) begin
                check({name, ".tx_start"}, tx_start, 1'b1);
                check({name, ".tx_index"}, tx_index, p.idx);
                check({name, ".tx_arg"}, tx_arg, p.arg);
            end else if (tx_start) tx_err++;
            exp_win = (p.typ != 2'b00) && t >= w0 && t < exp_done;
            if (rx_en !== exp_win || rx_r2 !== (exp_win && p.typ == 2'b10)) win_err++;
            if (busy !== (t < exp_done + NCC + 1) || req_ready !== (t >= exp_done + NCC + 1)) busy_err++;
            if (done) begin nd++; done_t = t; got_st = status; got_resp = resp; end
            tx_done     = (t == s);
            rx_started  = started && (t == st);
            rx_finished = finished && (t == fin);
            req_valid   = (t >= exp_done) && (t < exp_done + NCC + 1);
        end
        check({name, ".done_cnt"}, nd, 1);
        check({name, ".done_cycle"}, done_t, exp_done);
        check({name, ".status"}, got_st, exp_st);
        if (finished) check({name, ".resp"}, got_resp, exp_resp);
        check({name, ".status_held"}, status, exp_st);
        check({name, ".rx_window"}, win_err, 0);
        check({name, ".tx_start_once"}, tx_err, 0);
        check({name, ".busy_ready"}, busy_err, 0);
    endtask

    task automatic reset_mid();
        int nd;
        @(negedge clk);
        req_valid = 1'b1; req_index = 6'd17; req_arg = 32'h55; req_resp_type = 2'b01;
        @(negedge clk); req_valid = 1'b0; tx_done = 1'b1;
        @(negedge clk); tx_done = 1'b0; rx_started = 1'b1;
        @(negedge clk); rx_started = 1'b0;
        repeat (5) @(negedge clk);
        check("rst.rx_en_recv", rx_en, 1'b1);
        #2 reset = 1'b1;
        #1;
        check("rst.rx_en", rx_en, 1'b0);
        check("rst.busy_ready", {busy, req_ready, done}, 3'b010);
        check("rst.status", status, 3'b000);
        check("rst.resp", resp, 128'h0);
        check("rst.tx_regs", {tx_index, tx_arg}, 38'h0);
        @(negedge clk); reset = 1'b0;
        nd = 0;
        repeat (20) begin @(negedge clk); if (done) nd++; end
        check("rst.no_done", nd, 0);
        check("rst.idle", req_ready, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        plan_t p;
        reset = 1'b1; req_valid = 1'b0; req_index = '0; req_arg = '0; req_resp_type = '0;
        tx_done = 1'b0; rx_started = 1'b0; rx_finished = 1'b0; rx_response = '0;
        #12;
        check("reset.ctrl", {busy, req_ready, done, tx_start, rx_en, rx_r2}, 6'b010000);
        check("reset.status", status, 3'b000);
        check("reset.resp", resp, 128'h0);
        @(negedge clk); reset = 1'b0;

        run_txn("cmd0",      mk(2'b00, 6'd0,  32'h0,      3, 0,       0,       6'd0,  32'h0,     1'b0));
        run_txn("cmd8",      mk(2'b01, 6'd8,  32'h1AA,    2, 5,       48,      6'd8,  32'h1AA,   1'b0));
        run_txn("cmd17_ncr", mk(2'b01, 6'd17, 32'h1000,   1, NCR,     0,       6'd17, 32'h0,     1'b0));
        run_txn("cmd55_idx", mk(2'b01, 6'd55, 32'h0,      0, 3,       20,      6'h12, 32'h120,   1'b0));
        run_txn("cmd55_bc",  mk(2'b01, 6'd55, 32'h0,      0, 3,       20,      6'h12, 32'h120,   1'b1));
        run_txn("cmd55_c",   mk(2'b01, 6'd55, 32'h0,      1, 0,       0,       6'd55, 32'h920,   1'b1));
        run_txn("cmd2",      mk(2'b10, 6'd2,  32'h0,      1, 7,       130,     6'h3F, 32'h0,     1'b0));
        run_txn("edge_ties", mk(2'b01, 6'd13, 32'hABCD,   0, NCR - 1, RXM - 1, 6'd13, 32'hBEEF,  1'b0));
        run_txn("rx_to",     mk(2'b11, 6'd41, 32'h0,      2, 2,       RXM,     6'h3F, 32'h0,     1'b0));
        run_txn("r3_nochk",  mk(2'b11, 6'd41, 32'hFF00,   0, 4,       30,      6'h22, 32'h80FF8000, 1'b1));

        reset_mid();

        for (int i = 0; i < 25; i++) begin
            p.typ       = 2'($urandom_range(0, 3));
            p.idx       = 6'($urandom);
            p.arg       = $urandom;
            p.tx_lat    = $urandom_range(0, 4);
            p.start_lat = ($urandom_range(0, 9) == 0) ? NCR : $urandom_range(0, NCR - 1);
            case ($urandom_range(0, 9))
                0:       p.fin_lat = RXM;
                1:       p.fin_lat = RXM - 1;
                default: p.fin_lat = $urandom_range(0, 40);
            endcase
            p.resp_idx  = (p.typ == 2'b10) ? 6'h3F : p.idx;
            if ($urandom_range(0, 3) == 0) p.resp_idx = 6'($urandom);
            p.pay       = $urandom;
            p.bad_crc   = ($urandom_range(0, 3) == 0);
            run_txn($sformatf("rand%0d", i), p);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
